// File: rtl/gpu_barrier_ctrl_if.sv
// ---------------------------------------------------------------------------
// gpu_barrier_ctrl_if
// Handshake bundle between the GPU control unit, the barrier controller and
// the warp scheduler.
//   req_*  : barrier arrival channel (control unit -> barrier controller)
//            req_valid, req_wid, req_bar_id, req_count, req_ready (back)
//   rel_*  : release event channel (barrier controller -> warp scheduler)
//            rel_valid, rel_bar_id, rel_mask, rel_ready (back)
// Modports:
//   master : the requester / release consumer side
//   slave  : the barrier controller side
// ---------------------------------------------------------------------------
interface gpu_barrier_ctrl_if #(
   parameter int NUM_WARPS    = 4,
   parameter int NUM_BARRIERS = 4
);
   localparam int NW_BITS = $clog2(NUM_WARPS);
   localparam int NB_BITS = (NUM_BARRIERS > 1) ? $clog2(NUM_BARRIERS) : 1;

   logic                 req_valid;
   logic [NW_BITS-1:0]   req_wid;
   logic [NB_BITS-1:0]   req_bar_id;
   logic [NW_BITS:0]     req_count;
   logic                 req_ready;

   logic                 rel_valid;
   logic [NB_BITS-1:0]   rel_bar_id;
   logic [NUM_WARPS-1:0] rel_mask;
   logic                 rel_ready;

   modport master (
      output req_valid, req_wid, req_bar_id, req_count, rel_ready,
      input  req_ready, rel_valid, rel_bar_id, rel_mask
   );

   modport slave (
      input  req_valid, req_wid, req_bar_id, req_count, rel_ready,
      output req_ready, rel_valid, rel_bar_id, rel_mask
   );
endinterface

// File: rtl/gpu_barrier_ctrl.sv
// ---------------------------------------------------------------------------
// gpu_barrier_ctrl
// Warp barrier scheduler. Collects barrier arrivals per barrier table entry,
// keeps arrived warps stalled and, once the expected number of warps has
// arrived, emits one release event carrying the mask of warps to resume.
// Ports:
//   clk        : clock, all state updates on the rising edge
//   reset      : asynchronous active-low reset
//   bus        : slave side of gpu_barrier_ctrl_if (req_* in, rel_* out)
//   stall_mask : warps currently blocked at any barrier (incl. pending release)
//   dup_err    : one-cycle pulse, accepted request from an already waiting warp
// ---------------------------------------------------------------------------
module gpu_barrier_ctrl #(
   parameter int NUM_WARPS    = 4,
   parameter int NUM_BARRIERS = 4
) (
   input  logic                 clk,
   input  logic                 reset,
   gpu_barrier_ctrl_if.slave    bus,
   output logic [NUM_WARPS-1:0] stall_mask,
   output logic                 dup_err
);
   localparam int NW_BITS = $clog2(NUM_WARPS);
   localparam int NB_BITS = (NUM_BARRIERS > 1) ? $clog2(NUM_BARRIERS) : 1;
   localparam int CW      = NW_BITS + 1;

   typedef logic [CW-1:0]        cnt_t;
   typedef logic [NUM_WARPS-1:0] mask_t;
   typedef logic [NB_BITS-1:0]   bar_t;

   // barrier table
   logic  active_q   [NUM_BARRIERS];
   logic  active_d   [NUM_BARRIERS];
   cnt_t  expected_q [NUM_BARRIERS];
   cnt_t  expected_d [NUM_BARRIERS];
   cnt_t  arrived_q  [NUM_BARRIERS];
   cnt_t  arrived_d  [NUM_BARRIERS];
   mask_t wmask_q    [NUM_BARRIERS];
   mask_t wmask_d    [NUM_BARRIERS];

   // single-entry release register
   logic  rel_valid_q, rel_valid_d;
   bar_t  rel_bar_id_q, rel_bar_id_d;
   mask_t rel_mask_q, rel_mask_d;
   logic  dup_err_q, dup_err_d;

   logic  req_ready_w;
   logic  accept;
   cnt_t  eff;
   mask_t wbit;
   bar_t  idx;

   // A zero count still means "this warp alone"; more than NUM_WARPS can
   // never be satisfied, so it is clamped to all warps.
   function automatic cnt_t norm_count(input cnt_t c);
      if (c == '0)
         return CW'(1);
      else if (c > CW'(NUM_WARPS))
         return CW'(NUM_WARPS);
      else
         return c;
   endfunction

   always_comb begin
      active_d     = active_q;
      expected_d   = expected_q;
      arrived_d    = arrived_q;
      wmask_d      = wmask_q;
      rel_valid_d  = rel_valid_q;
      rel_bar_id_d = rel_bar_id_q;
      rel_mask_d   = rel_mask_q;
      dup_err_d    = 1'b0;

      // A new release may load in the same cycle the old one drains.
      req_ready_w = !rel_valid_q || bus.rel_ready;
      accept      = bus.req_valid && req_ready_w;
      eff         = norm_count(bus.req_count);
      idx         = bus.req_bar_id;
      wbit        = '0;
      wbit[bus.req_wid] = 1'b1;

      if (rel_valid_q && bus.rel_ready) begin
         rel_valid_d  = 1'b0;
         rel_bar_id_d = '0;
         rel_mask_d   = '0;
      end

      if (accept) begin
         if (!active_q[idx]) begin
            if (eff == CW'(1)) begin
               // single-warp barrier releases immediately, entry stays idle
               rel_valid_d  = 1'b1;
               rel_bar_id_d = idx;
               rel_mask_d   = wbit;
            end else begin
               active_d[idx]   = 1'b1;
               expected_d[idx] = eff;
               arrived_d[idx]  = CW'(1);
               wmask_d[idx]    = wbit;
            end
         end else if ((wmask_q[idx] & wbit) != '0) begin
            dup_err_d = 1'b1;
         end else if (arrived_q[idx] + CW'(1) == expected_q[idx]) begin
            rel_valid_d    = 1'b1;
            rel_bar_id_d   = idx;
            rel_mask_d     = wmask_q[idx] | wbit;
            active_d[idx]  = 1'b0;
            arrived_d[idx] = '0;
            wmask_d[idx]   = '0;
         end else begin
            // later arrivals ignore req_count; the first arrival's count wins
            arrived_d[idx] = arrived_q[idx] + CW'(1);
            wmask_d[idx]   = wmask_q[idx] | wbit;
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int b = 0; b < NUM_BARRIERS; b++) begin
            active_q[b]   <= 1'b0;
            expected_q[b] <= '0;
            arrived_q[b]  <= '0;
            wmask_q[b]    <= '0;
         end
         rel_valid_q  <= 1'b0;
         rel_bar_id_q <= '0;
         rel_mask_q   <= '0;
         dup_err_q    <= 1'b0;
      end else begin
         active_q     <= active_d;
         expected_q   <= expected_d;
         arrived_q    <= arrived_d;
         wmask_q      <= wmask_d;
         rel_valid_q  <= rel_valid_d;
         rel_bar_id_q <= rel_bar_id_d;
         rel_mask_q   <= rel_mask_d;
         dup_err_q    <= dup_err_d;
      end
   end

   // Released warps remain stalled until the scheduler takes the event.
   always_comb begin
      stall_mask = '0;
      for (int b = 0; b < NUM_BARRIERS; b++)
         stall_mask = stall_mask | wmask_q[b];
      if (rel_valid_q)
         stall_mask = stall_mask | rel_mask_q;
   end

   assign bus.req_ready  = req_ready_w;
   assign bus.rel_valid  = rel_valid_q;
   assign bus.rel_bar_id = rel_bar_id_q;
   assign bus.rel_mask   = rel_mask_q;
   assign dup_err        = dup_err_q;

endmodule

// File: tb/tb_gpu_barrier_ctrl.sv
module tb_gpu_barrier_ctrl;
   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic [3:0] stall_mask;
   logic       dup_err;

   int n_cmp = 0;
   int n_err = 0;

   typedef struct {
      logic [1:0] bar;
      logic [3:0] mask;
   } rel_t;

   rel_t rel_q[$];
   bit   dup_q[$];

   gpu_barrier_ctrl_if #(.NUM_WARPS(4), .NUM_BARRIERS(4)) bus ();

   gpu_barrier_ctrl #(.NUM_WARPS(4), .NUM_BARRIERS(4)) dut (
      .clk        (clk),
      .reset      (reset),
      .bus        (bus),
      .stall_mask (stall_mask),
      .dup_err    (dup_err)
   );

   always #5 clk = ~clk;

   function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endfunction

   // Monitor: the release handshake completes at the next rising edge when
   // valid and ready are both high mid-cycle.
   initial begin
      rel_t e;
      forever begin
         @(negedge clk);
         if (reset) begin
            if (bus.rel_valid && bus.rel_ready) begin
               if (rel_q.size() == 0) begin
                  n_cmp++;
                  n_err++;
                  $display("FAIL unexpected_release: got bar %0d mask %b, expected none", bus.rel_bar_id, bus.rel_mask);
               end else begin
                  e = rel_q.pop_front();
                  check("rel_bar_id", 32'(bus.rel_bar_id), 32'(e.bar));
                  check("rel_mask", 32'(bus.rel_mask), 32'(e.mask));
               end
            end
            if (dup_err) begin
               if (dup_q.size() == 0) begin
                  n_cmp++;
                  n_err++;
                  $display("FAIL unexpected_dup_err: got 1, expected 0");
               end else begin
                  void'(dup_q.pop_front());
                  check("dup_err", 32'(dup_err), 32'd1);
               end
            end
         end
      end
   end

   // Issue one request, hold it until accepted; returns 1ns after the
   // accepting edge.
   task automatic send(input int wid, input int bar, input int cnt);
      bit ok;
      ok = 1'b0;
      bus.req_valid  = 1'b1;
      bus.req_wid    = 2'(wid);
      bus.req_bar_id = 2'(bar);
      bus.req_count  = 3'(cnt);
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         ok = bus.req_ready;
         @(posedge clk);
         #1;
         if (ok) break;
      end
      bus.req_valid = 1'b0;
      if (!ok) check("req_accept_timeout", 32'd0, 32'd1);
   endtask

   task automatic drain();
      bus.rel_ready = 1'b1;
      for (int i = 0; i < 10; i++) begin
         @(posedge clk);
         #1;
         if (!bus.rel_valid) break;
      end
      bus.rel_ready = 1'b0;
      check("drain_rel_valid", 32'(bus.rel_valid), 32'd0);
   endtask

   task automatic push_rel(input int bar, input int mask);
      rel_t e;
      e.bar  = 2'(bar);
      e.mask = 4'(mask);
      rel_q.push_back(e);
   endtask

   initial begin
      bus.req_valid  = 1'b0;
      bus.req_wid    = '0;
      bus.req_bar_id = '0;
      bus.req_count  = '0;
      bus.rel_ready  = 1'b0;

      // reset state
      repeat (2) @(posedge clk);
      #1;
      check("rst_rel_valid", 32'(bus.rel_valid), 32'd0);
      check("rst_rel_bar_id", 32'(bus.rel_bar_id), 32'd0);
      check("rst_rel_mask", 32'(bus.rel_mask), 32'd0);
      check("rst_stall", 32'(stall_mask), 32'd0);
      check("rst_dup", 32'(dup_err), 32'd0);
      @(negedge clk);
      reset = 1'b1;
      @(posedge clk);
      #1;
      check("idle_req_ready", 32'(bus.req_ready), 32'd1);
      check("idle_rel_valid", 32'(bus.rel_valid), 32'd0);
      check("idle_stall", 32'(stall_mask), 32'd0);

      // reset in the middle of a barrier
      send(0, 1, 2);
      check("midrst_stall_before", 32'(stall_mask), 32'b0001);
      #2 reset = 1'b0;
      #1;
      check("midrst_stall_async", 32'(stall_mask), 32'd0);
      @(negedge clk);
      reset = 1'b1;
      @(posedge clk);
      #1;
      send(1, 1, 2);
      check("midrst_entry_cleared", 32'(stall_mask), 32'b0010);
      push_rel(1, 4'b0110);
      send(2, 1, 2);
      drain();
      check("midrst_stall_after", 32'(stall_mask), 32'd0);

      // three warps, back-to-back, barrier 2
      push_rel(2, 4'b0111);
      send(0, 2, 3);
      check("b2b_stall1", 32'(stall_mask), 32'b0001);
      send(1, 2, 3);
      check("b2b_stall2", 32'(stall_mask), 32'b0011);
      check("b2b_no_rel", 32'(bus.rel_valid), 32'd0);
      send(2, 2, 3);
      check("b2b_rel_valid", 32'(bus.rel_valid), 32'd1);
      check("b2b_stall3", 32'(stall_mask), 32'b0111);
      repeat (3) @(posedge clk);
      #1;
      check("b2b_hold_valid", 32'(bus.rel_valid), 32'd1);
      check("b2b_hold_mask", 32'(bus.rel_mask), 32'b0111);
      check("b2b_hold_stall", 32'(stall_mask), 32'b0111);
      check("b2b_req_ready_low", 32'(bus.req_ready), 32'd0);
      drain();
      check("b2b_stall_clear", 32'(stall_mask), 32'd0);

      // single-warp barrier, count 0
      push_rel(0, 4'b1000);
      send(3, 0, 0);
      check("single_rel_valid", 32'(bus.rel_valid), 32'd1);
      check("single_stall", 32'(stall_mask), 32'b1000);
      drain();

      // count 7 saturates to 4
      send(3, 0, 7);
      send(0, 0, 7);
      send(1, 0, 7);
      check("sat_no_rel", 32'(bus.rel_valid), 32'd0);
      check("sat_stall", 32'(stall_mask), 32'b1011);
      push_rel(0, 4'b1111);
      send(2, 0, 7);
      check("sat_rel_valid", 32'(bus.rel_valid), 32'd1);
      drain();

      // duplicate arrival
      send(1, 1, 2);
      dup_q.push_back(1'b1);
      send(1, 1, 2);
      check("dup_pulse", 32'(dup_err), 32'd1);
      check("dup_stall", 32'(stall_mask), 32'b0010);
      check("dup_no_rel", 32'(bus.rel_valid), 32'd0);
      @(posedge clk);
      #1;
      check("dup_pulse_end", 32'(dup_err), 32'd0);
      push_rel(1, 4'b0110);
      send(2, 1, 2);
      check("dup_rel_valid", 32'(bus.rel_valid), 32'd1);
      drain();

      // backpressure with drain and reload in the same cycle
      push_rel(3, 4'b0001);
      send(0, 3, 1);
      push_rel(2, 4'b0010);
      fork
         send(1, 2, 1);
         begin
            repeat (3) begin
               @(posedge clk);
               #2;
               check("bp_req_ready_low", 32'(bus.req_ready), 32'd0);
               check("bp_old_bar", 32'(bus.rel_bar_id), 32'd3);
            end
            bus.rel_ready = 1'b1;
            @(posedge clk);
            #2;
            bus.rel_ready = 1'b0;
         end
      join
      check("bp_new_valid", 32'(bus.rel_valid), 32'd1);
      check("bp_new_bar", 32'(bus.rel_bar_id), 32'd2);
      check("bp_new_mask", 32'(bus.rel_mask), 32'b0010);
      drain();

      // interleaved barriers
      send(0, 0, 2);
      send(1, 1, 2);
      check("il_stall", 32'(stall_mask), 32'b0011);
      bus.rel_ready = 1'b1;
      push_rel(1, 4'b0110);
      send(2, 1, 2);
      push_rel(0, 4'b1001);
      send(3, 0, 2);
      drain();
      check("il_stall_clear", 32'(stall_mask), 32'd0);

      repeat (3) @(posedge clk);
      #1;
      check("rel_queue_empty", 32'(rel_q.size()), 32'd0);
      check("dup_queue_empty", 32'(dup_q.size()), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: got timeout, expected completion");
      $fatal(1, "timeout");
   end
endmodule
